des_key_schedule: RTL and testbench

Iterative DES subkey generator. Accepts a 64-bit key, applies PC-1, then emits the 16 round subkeys (48 bits, after PC-2) one per handshake, in encrypt order (K1..K16) or decrypt order (K16..K1). It sits directly upstream of the round XOR that feeds `s_function`: `E(R) ^ sk` forms the 48-bit S-box input.

---
 rtl/des_pkg.sv | 64 ++++++
 rtl/des_pc2.sv | 17 +
 rtl/des_key_schedule.sv | 103 ++++++++++
 tb/tb_des_key_schedule.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: permutation tables, PC-1, 28-bit rotations,
// widths, the schedule state enum and the standard per-round shift map.
package des_pkg;

  localparam int DES_KEY_W = 64;
  localparam int DES_CD_W  = 28;
  localparam int DES_SK_W  = 48;

  // Bit i set: round i+1 rotates by one place, otherwise by two.
  localparam logic [15:0] DES_SHIFT_MAP_DEFAULT = 16'h8103;

  typedef enum logic {IDLE, RUN} ks_state_e;

  localparam int PC1_TAB [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Tables use DES numbering (bit 1 = MSB), so bit n lives at index W-n.
  function automatic logic [2*DES_CD_W-1:0] pc1(input logic [DES_KEY_W-1:0] k);
    logic [2*DES_CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < 2*DES_CD_W; i++) begin
      r[6'(2*DES_CD_W-1-i)] = k[6'(DES_KEY_W-PC1_TAB[i])];
    end
    return r;
  endfunction

  function automatic logic [DES_CD_W-1:0] rotl28(input logic [DES_CD_W-1:0] x,
                                                 input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [DES_CD_W-1:0] rotr28(input logic [DES_CD_W-1:0] x,
                                                 input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES PC-2: combinational 56->48 selection from the {C,D} halves.
// Zero latency, no handshake; shared with the round pipeline.
module des_pc2
  import des_pkg::*;
(
  input  logic [2*DES_CD_W-1:0] cd,
  output logic [DES_SK_W-1:0]   sk
);

  always_comb begin
    sk = '0;
    for (int i = 0; i < DES_SK_W; i++) begin
      sk[6'(DES_SK_W-1-i)] = cd[6'(2*DES_CD_W-PC2_TAB[i])];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES subkey generator: one key in, 16 subkeys out in encrypt or decrypt order.
// First subkey the cycle after key accept; sk_ready=0 holds the current subkey indefinitely.
module des_key_schedule
  import des_pkg::*;
#(
  parameter logic [15:0] SHIFT_MAP = DES_SHIFT_MAP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [DES_KEY_W-1:0] key,
  input  logic                 decrypt,
  input  logic                 flush,
  output logic                 sk_valid,
  input  logic                 sk_ready,
  output logic [DES_SK_W-1:0]  sk,
  output logic [3:0]           sk_idx,
  output logic                 sk_last
);

  ks_state_e             state_q, state_d;
  logic [DES_CD_W-1:0]   c_q, c_d, d_q, d_d;
  logic [3:0]            idx_q, idx_d;
  logic                  dec_q, dec_d;

  logic [2*DES_CD_W-1:0] pc1_key;
  logic [DES_CD_W-1:0]   pc1_c, pc1_d;
  logic [1:0]            sh_load, sh_enc, sh_dec;

  function automatic logic [1:0] shift_of(input logic [3:0] map_bit);
    return SHIFT_MAP[map_bit] ? 2'd1 : 2'd2;
  endfunction

  assign pc1_key = pc1(key);
  assign pc1_c   = pc1_key[2*DES_CD_W-1:DES_CD_W];
  assign pc1_d   = pc1_key[DES_CD_W-1:0];

  // Next encrypt round is idx+2 (map bit idx+1); decrypt undoes round 16-idx (map bit 15-idx).
  assign sh_load = shift_of(4'd0);
  assign sh_enc  = shift_of(idx_q + 4'd1);
  assign sh_dec  = shift_of(4'd15 - idx_q);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d = RUN;
          dec_d   = decrypt;
          idx_d   = 4'd0;
          // Unrotated PC-1 output is already K16 since the full schedule rotates by 28.
          c_d     = decrypt ? pc1_c : rotl28(pc1_c, sh_load);
          d_d     = decrypt ? pc1_d : rotl28(pc1_d, sh_load);
        end
      end
      RUN: begin
        if (flush || (sk_ready && idx_q == 4'd15)) begin
          state_d = IDLE;
          c_d     = '0;
          d_d     = '0;
          idx_d   = 4'd0;
        end else if (sk_ready) begin
          idx_d = idx_q + 4'd1;
          c_d   = dec_q ? rotr28(c_q, sh_dec) : rotl28(c_q, sh_enc);
          d_d   = dec_q ? rotr28(d_q, sh_dec) : rotl28(d_q, sh_enc);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      idx_q   <= 4'd0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
    end
  end

  assign key_ready = (state_q == IDLE);
  assign sk_valid  = (state_q == RUN);
  assign sk_idx    = idx_q;
  assign sk_last   = sk_valid && (idx_q == 4'd15);

  des_pc2 u_pc2 (
    .cd ({c_q, d_q}),
    .sk (sk)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule against the classic 133457799BBCDFF1 subkey set.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst, key_valid, decrypt, flush, sk_ready;
  logic        key_ready, sk_valid, sk_last;
  logic [63:0] key;
  logic [47:0] sk;
  logic [3:0]  sk_idx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [47:0] ref_k [16];

  typedef struct {
    logic [63:0] key;
    logic        dec;
    int          stall_at;
    int          stall_len;
    logic [47:0] exp_first;
    logic [47:0] exp_last;
  } sched_t;

  sched_t tbl [5];

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .decrypt   (decrypt),
    .flush     (flush),
    .sk_valid  (sk_valid),
    .sk_ready  (sk_ready),
    .sk        (sk),
    .sk_idx    (sk_idx),
    .sk_last   (sk_last)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] exp_sk(input logic dec, input int i);
    return dec ? ref_k[15-i] : ref_k[i];
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_key_ready"}, key_ready, 1);
    check({tag, "_sk_valid"},  sk_valid,  0);
    check({tag, "_sk"},        sk,        0);
    check({tag, "_sk_idx"},    sk_idx,    0);
    check({tag, "_sk_last"},   sk_last,   0);
  endtask

  task automatic start_key(input logic [63:0] k, input logic d);
    key       = k;
    decrypt   = d;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    key       = '0;
    decrypt   = 1'b0;
  endtask

  task automatic run_sched(input sched_t s, input int n);
    start_key(s.key, s.dec);
    for (int i = 0; i < 16; i++) begin
      if (i == s.stall_at) begin
        sk_ready = 1'b0;
        for (int j = 0; j < s.stall_len; j++) begin
          step();
          check($sformatf("s%0d_hold%0d_sk", n, j),    sk,       exp_sk(s.dec, i));
          check($sformatf("s%0d_hold%0d_idx", n, j),   sk_idx,   i);
          check($sformatf("s%0d_hold%0d_valid", n, j), sk_valid, 1);
        end
        sk_ready = 1'b1;
      end
      check($sformatf("s%0d_sk%0d", n, i),    sk,        exp_sk(s.dec, i));
      check($sformatf("s%0d_idx%0d", n, i),   sk_idx,    i);
      check($sformatf("s%0d_last%0d", n, i),  sk_last,   (i == 15));
      check($sformatf("s%0d_valid%0d", n, i), sk_valid,  1);
      check($sformatf("s%0d_kr%0d", n, i),    key_ready, 0);
      if (i == 0)  check($sformatf("s%0d_first", n), sk, s.exp_first);
      if (i == 15) check($sformatf("s%0d_last", n),  sk, s.exp_last);
      step();
    end
    check_idle($sformatf("s%0d_done", n));
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key       = '0;
    decrypt   = 1'b0;
    flush     = 1'b0;
    sk_ready  = 1'b1;

    ref_k = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
              48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
              48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
              48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

    tbl[0] = '{64'h133457799BBCDFF1, 1'b0, 16, 0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    tbl[1] = '{64'h133457799BBCDFF1, 1'b1, 16, 0, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
    tbl[2] = '{64'h133457799BBCDFF1, 1'b0,  3, 5, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    tbl[3] = '{64'h123456789ABCDEF0, 1'b0, 16, 0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    tbl[4] = '{64'h123456789ABCDEF0, 1'b1, 10, 2, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};

    repeat (2) step();
    check_idle("reset");
    rst = 1'b0;
    step();
    check_idle("post_reset");

    flush = 1'b1;
    step();
    flush = 1'b0;
    check_idle("idle_flush");

    for (int t = 0; t < 5; t++) run_sched(tbl[t], t);

    // A key offered mid-run must be ignored, then flush at idx 7 drops the schedule.
    start_key(64'h133457799BBCDFF1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("fl_sk%0d", i), sk, ref_k[i]);
      if (i == 6) begin
        key       = 64'h0E329232EA6D0D73;
        decrypt   = 1'b1;
        key_valid = 1'b1;
      end
      step();
    end
    key_valid = 1'b0;
    key       = '0;
    decrypt   = 1'b0;
    check("rej_idx", sk_idx, 7);
    check("rej_sk",  sk,     ref_k[7]);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_idle("flush7");
    run_sched(tbl[1], 5);

    // Flush coinciding with the final transfer.
    start_key(64'h133457799BBCDFF1, 1'b1);
    repeat (15) step();
    check("fl15_last", sk_last, 1);
    check("fl15_sk",   sk,      ref_k[0]);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_idle("flush15");
    step();
    check_idle("flush15_stay");

    // Reset mid-run at idx 9.
    start_key(64'h133457799BBCDFF1, 1'b0);
    repeat (9) step();
    check("rst9_idx", sk_idx, 9);
    check("rst9_sk",  sk,     ref_k[9]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("rst9");
    run_sched(tbl[0], 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
